// File: rtl/VX_tex_pkg.sv
// Shared texture-path definitions: LOD/stage widths, derived-width helpers and the
// request payload layout used on the arbitrated texture request port.
package VX_tex_pkg;

  localparam int VX_TEX_LOD_BITS   = 4;
  localparam int VX_TEX_STAGE_BITS = 2;
  localparam int TEX_DEF_LANES     = 4;
  localparam int TEX_DEF_TAG_BITS  = 10;

  function automatic int clog2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic int sel_bits(input int num_inputs);
    return (num_inputs > 1) ? clog2_f(num_inputs) : 1;
  endfunction

  function automatic int cnt_bits(input int max_pending);
    return clog2_f(max_pending + 1);
  endfunction

  typedef struct packed {
    logic [TEX_DEF_LANES-1:0]                        mask;
    logic [1:0][TEX_DEF_LANES-1:0][31:0]             coords;
    logic [TEX_DEF_LANES-1:0][VX_TEX_LOD_BITS-1:0]   lod;
    logic [VX_TEX_STAGE_BITS-1:0]                    stage;
    logic [TEX_DEF_TAG_BITS-1:0]                     tag;
  } tex_arb_req_t;

endpackage

// File: rtl/VX_elastic_buffer.sv
// Single-entry valid/ready register stage. With SIZE 1 and OUT_REG 0 it runs in
// pipe mode: a full entry can be replaced in the same cycle it drains.
module VX_elastic_buffer #(
  parameter int DATAW   = 1,
  parameter int SIZE    = 1,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DATAW-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [DATAW-1:0] data_o
);

  localparam logic PIPE_READY = (SIZE == 1) && (OUT_REG == 0);

  logic             valid_q, valid_d;
  logic [DATAW-1:0] data_q;
  logic             load_s;

  assign ready_o = ~valid_q | (ready_i & PIPE_READY);
  assign load_s  = valid_i & ready_o;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    if (load_s) begin
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // Payload carries no reset; it is only observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (load_s) data_q <= data_i;
  end

endmodule

// File: rtl/tex_req_arbiter_checker.sv
// Simulation-only protocol checks for the texture request arbiter: response routing
// range, responses without outstanding credit, and credit counter overflow.
module tex_req_arbiter_checker #(
  parameter int NUM_INPUTS  = 4,
  parameter int MAX_PENDING = 8,
  parameter int SEL_BITS    = 2,
  parameter int CNT_BITS    = 4
) (
  input logic                                 clk,
  input logic                                 reset,
  input logic                                 tex_rsp_fire_i,
  input logic [SEL_BITS-1:0]                  rsp_sel_i,
  input logic [NUM_INPUTS-1:0][CNT_BITS-1:0]  pend_cnt_i,
  input logic [NUM_INPUTS-1:0]                req_fire_i,
  input logic [NUM_INPUTS-1:0]                rsp_fire_i
);

  logic sel_in_range_s;
  logic pend_nonzero_s;
  logic overflow_s;

  always_comb begin
    sel_in_range_s = int'(rsp_sel_i) < NUM_INPUTS;
    pend_nonzero_s = 1'b1;
    if (sel_in_range_s) begin
      pend_nonzero_s = pend_cnt_i[rsp_sel_i] != '0;
    end else begin
      pend_nonzero_s = 1'b1;
    end
    overflow_s = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (req_fire_i[i] && !rsp_fire_i[i] && (pend_cnt_i[i] == CNT_BITS'(MAX_PENDING))) begin
        overflow_s = 1'b1;
      end else begin
        overflow_s = overflow_s;
      end
    end
  end

  a_rsp_sel_range: assert property (@(posedge clk) disable iff (reset)
    tex_rsp_fire_i |-> sel_in_range_s);
  a_rsp_has_credit: assert property (@(posedge clk) disable iff (reset)
    tex_rsp_fire_i |-> pend_nonzero_s);
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !overflow_s);

endmodule

// File: rtl/tex_rr_arbiter.sv
// N-way round-robin grant: the first request at or after the pointer wins and the
// pointer moves past the winner only when the grant is consumed.
module tex_rr_arbiter
  import VX_tex_pkg::*;
#(
  parameter  int N        = 4,
  localparam int SEL_BITS = sel_bits(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        requests_i,
  input  logic                grant_ready_i,
  output logic                grant_valid_o,
  output logic [SEL_BITS-1:0] grant_index_o
);

  if (N == 1) begin : g_single
    assign grant_valid_o = requests_i[0];
    assign grant_index_o = '0;
  end else begin : g_rr
    logic [SEL_BITS-1:0] ptr_q, ptr_d;
    int                  idx;

    // Scan from the farthest offset down so the closest eligible index is kept.
    always_comb begin
      grant_valid_o = 1'b0;
      grant_index_o = ptr_q;
      idx           = 0;
      for (int k = N - 1; k >= 0; k--) begin
        idx = (int'(ptr_q) + k) % N;
        if (requests_i[idx]) begin
          grant_valid_o = 1'b1;
          grant_index_o = SEL_BITS'(idx);
        end else begin
          grant_valid_o = grant_valid_o;
        end
      end
    end

    always_comb begin
      ptr_d = ptr_q;
      if (grant_valid_o && grant_ready_i) begin
        ptr_d = (grant_index_o == SEL_BITS'(N - 1)) ? '0 : grant_index_o + SEL_BITS'(1);
      end else begin
        ptr_d = ptr_q;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tex_req_arbiter.sv
// Round-robin arbiter from NUM_INPUTS texture requesters onto one texture unit port,
// with per-input credit limits and tag-based routing of responses back to the source.
module tex_req_arbiter
  import VX_tex_pkg::*;
#(
  parameter  int NUM_INPUTS  = 4,
  parameter  int NUM_LANES   = 4,
  parameter  int TAG_WIDTH   = 8,
  parameter  int MAX_PENDING = 8,
  localparam int SEL_BITS    = sel_bits(NUM_INPUTS),
  localparam int CNT_BITS    = cnt_bits(MAX_PENDING)
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_INPUTS-1:0]                                  in_req_valid,
  input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0]                   in_req_mask,
  input  logic [NUM_INPUTS-1:0][1:0][NUM_LANES-1:0][31:0]        in_req_coords,
  input  logic [NUM_INPUTS-1:0][NUM_LANES-1:0][VX_TEX_LOD_BITS-1:0] in_req_lod,
  input  logic [NUM_INPUTS-1:0][VX_TEX_STAGE_BITS-1:0]           in_req_stage,
  input  logic [NUM_INPUTS-1:0][TAG_WIDTH-1:0]                   in_req_tag,
  output logic [NUM_INPUTS-1:0]                                  in_req_ready,
  output logic [NUM_INPUTS-1:0]                                  in_rsp_valid,
  output logic [NUM_LANES-1:0][31:0]                             in_rsp_texels,
  output logic [TAG_WIDTH-1:0]                                   in_rsp_tag,
  input  logic [NUM_INPUTS-1:0]                                  in_rsp_ready,
  output logic                                                   tex_req_valid,
  output logic [NUM_LANES-1:0]                                   tex_req_mask,
  output logic [1:0][NUM_LANES-1:0][31:0]                        tex_req_coords,
  output logic [NUM_LANES-1:0][VX_TEX_LOD_BITS-1:0]              tex_req_lod,
  output logic [VX_TEX_STAGE_BITS-1:0]                           tex_req_stage,
  output logic [TAG_WIDTH+SEL_BITS-1:0]                          tex_req_tag,
  input  logic                                                   tex_req_ready,
  input  logic                                                   tex_rsp_valid,
  input  logic [NUM_LANES-1:0][31:0]                             tex_rsp_texels,
  input  logic [TAG_WIDTH+SEL_BITS-1:0]                          tex_rsp_tag,
  output logic                                                   tex_rsp_ready
);

  typedef struct packed {
    logic [NUM_LANES-1:0]                        mask;
    logic [1:0][NUM_LANES-1:0][31:0]             coords;
    logic [NUM_LANES-1:0][VX_TEX_LOD_BITS-1:0]   lod;
    logic [VX_TEX_STAGE_BITS-1:0]                stage;
    logic [TAG_WIDTH+SEL_BITS-1:0]               tag;
  } req_data_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][31:0]    texels;
    logic [TAG_WIDTH+SEL_BITS-1:0] tag;
  } rsp_data_t;

  logic [NUM_INPUTS-1:0][CNT_BITS-1:0] pend_cnt_q, pend_cnt_d;
  logic [NUM_INPUTS-1:0]               eligible_s;
  logic [NUM_INPUTS-1:0]               req_fire_s, rsp_fire_s;
  logic                                grant_valid_s;
  logic [SEL_BITS-1:0]                 grant_index_s;
  logic                                req_stage_ready_s;
  logic                                accept_s;
  req_data_t                           req_data_s, req_q_s;
  rsp_data_t                           rsp_in_s, rsp_q_s;
  logic                                rsp_valid_s;
  logic [SEL_BITS-1:0]                 rsp_sel_s;
  logic                                rsp_out_ready_s;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      eligible_s[i] = in_req_valid[i] && (pend_cnt_q[i] < CNT_BITS'(MAX_PENDING));
    end
  end

  tex_rr_arbiter #(.N(NUM_INPUTS)) u_arb (
    .clk           (clk),
    .reset         (reset),
    .requests_i    (eligible_s),
    .grant_ready_i (req_stage_ready_s & ~reset),
    .grant_valid_o (grant_valid_s),
    .grant_index_o (grant_index_s)
  );

  // Ready is masked during reset so nothing is accepted into state being cleared.
  assign accept_s = grant_valid_s & req_stage_ready_s & ~reset;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_req_ready[i] = accept_s && (grant_index_s == SEL_BITS'(i));
    end
  end

  always_comb begin
    req_data_s.mask   = in_req_mask[grant_index_s];
    req_data_s.coords = in_req_coords[grant_index_s];
    req_data_s.lod    = in_req_lod[grant_index_s];
    req_data_s.stage  = in_req_stage[grant_index_s];
    req_data_s.tag    = {in_req_tag[grant_index_s], grant_index_s};
  end

  VX_elastic_buffer #(.DATAW($bits(req_data_t)), .SIZE(1), .OUT_REG(0)) u_req_buf (
    .clk     (clk),
    .reset   (reset),
    .valid_i (grant_valid_s & ~reset),
    .ready_o (req_stage_ready_s),
    .data_i  (req_data_s),
    .valid_o (tex_req_valid),
    .ready_i (tex_req_ready),
    .data_o  (req_q_s)
  );

  assign tex_req_mask   = req_q_s.mask;
  assign tex_req_coords = req_q_s.coords;
  assign tex_req_lod    = req_q_s.lod;
  assign tex_req_stage  = req_q_s.stage;
  assign tex_req_tag    = req_q_s.tag;

  assign rsp_in_s = '{texels: tex_rsp_texels, tag: tex_rsp_tag};

  VX_elastic_buffer #(.DATAW($bits(rsp_data_t)), .SIZE(1), .OUT_REG(0)) u_rsp_buf (
    .clk     (clk),
    .reset   (reset),
    .valid_i (tex_rsp_valid),
    .ready_o (tex_rsp_ready),
    .data_i  (rsp_in_s),
    .valid_o (rsp_valid_s),
    .ready_i (rsp_out_ready_s),
    .data_o  (rsp_q_s)
  );

  assign rsp_sel_s     = (NUM_INPUTS == 1) ? '0 : rsp_q_s.tag[SEL_BITS-1:0];
  assign in_rsp_texels = rsp_q_s.texels;
  assign in_rsp_tag    = rsp_q_s.tag[TAG_WIDTH+SEL_BITS-1:SEL_BITS];

  // A stray out-of-range selector is drained rather than allowed to wedge the port.
  always_comb begin
    if (int'(rsp_sel_s) < NUM_INPUTS) begin
      rsp_out_ready_s = in_rsp_ready[rsp_sel_s];
    end else begin
      rsp_out_ready_s = 1'b1;
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_rsp_valid[i] = rsp_valid_s && (rsp_sel_s == SEL_BITS'(i));
    end
  end

  assign req_fire_s = in_req_valid & in_req_ready;
  assign rsp_fire_s = in_rsp_valid & in_rsp_ready;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (req_fire_s[i] && !rsp_fire_s[i]) begin
        pend_cnt_d[i] = pend_cnt_q[i] + CNT_BITS'(1);
      end else if (rsp_fire_s[i] && !req_fire_s[i]) begin
        pend_cnt_d[i] = pend_cnt_q[i] - CNT_BITS'(1);
      end else begin
        pend_cnt_d[i] = pend_cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pend_cnt_q <= '0;
    else       pend_cnt_q <= pend_cnt_d;
  end

  tex_req_arbiter_checker #(
    .NUM_INPUTS  (NUM_INPUTS),
    .MAX_PENDING (MAX_PENDING),
    .SEL_BITS    (SEL_BITS),
    .CNT_BITS    (CNT_BITS)
  ) u_checker (
    .clk            (clk),
    .reset          (reset),
    .tex_rsp_fire_i (tex_rsp_valid & tex_rsp_ready),
    .rsp_sel_i      ((NUM_INPUTS == 1) ? SEL_BITS'(0) : tex_rsp_tag[SEL_BITS-1:0]),
    .pend_cnt_i     (pend_cnt_q),
    .req_fire_i     (req_fire_s),
    .rsp_fire_i     (rsp_fire_s)
  );

endmodule

// File: tb/tb_tex_req_arbiter.sv
// Directed bench for tex_req_arbiter (4 inputs, MAX_PENDING 2): each task drives a
// scenario cycle by cycle and compares outputs against hand-computed values.
module tb_tex_req_arbiter;
  import VX_tex_pkg::*;

  localparam int N  = 4;
  localparam int L  = 4;
  localparam int TW = 8;
  localparam int MP = 2;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]                              in_req_valid;
  logic [N-1:0][L-1:0]                       in_req_mask;
  logic [N-1:0][1:0][L-1:0][31:0]            in_req_coords;
  logic [N-1:0][L-1:0][VX_TEX_LOD_BITS-1:0]  in_req_lod;
  logic [N-1:0][VX_TEX_STAGE_BITS-1:0]       in_req_stage;
  logic [N-1:0][TW-1:0]                      in_req_tag;
  logic [N-1:0]                              in_req_ready;
  logic [N-1:0]                              in_rsp_valid;
  logic [L-1:0][31:0]                        in_rsp_texels;
  logic [TW-1:0]                             in_rsp_tag;
  logic [N-1:0]                              in_rsp_ready;
  logic                                      tex_req_valid;
  logic [L-1:0]                              tex_req_mask;
  logic [1:0][L-1:0][31:0]                   tex_req_coords;
  logic [L-1:0][VX_TEX_LOD_BITS-1:0]         tex_req_lod;
  logic [VX_TEX_STAGE_BITS-1:0]              tex_req_stage;
  logic [TW+SB-1:0]                          tex_req_tag;
  logic                                      tex_req_ready;
  logic                                      tex_rsp_valid;
  logic [L-1:0][31:0]                        tex_rsp_texels;
  logic [TW+SB-1:0]                          tex_rsp_tag;
  logic                                      tex_rsp_ready;

  int checks = 0;
  int errors = 0;

  tex_req_arbiter #(.NUM_INPUTS(N), .NUM_LANES(L), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .in_req_valid(in_req_valid), .in_req_mask(in_req_mask), .in_req_coords(in_req_coords),
    .in_req_lod(in_req_lod), .in_req_stage(in_req_stage), .in_req_tag(in_req_tag),
    .in_req_ready(in_req_ready),
    .in_rsp_valid(in_rsp_valid), .in_rsp_texels(in_rsp_texels), .in_rsp_tag(in_rsp_tag),
    .in_rsp_ready(in_rsp_ready),
    .tex_req_valid(tex_req_valid), .tex_req_mask(tex_req_mask), .tex_req_coords(tex_req_coords),
    .tex_req_lod(tex_req_lod), .tex_req_stage(tex_req_stage), .tex_req_tag(tex_req_tag),
    .tex_req_ready(tex_req_ready),
    .tex_rsp_valid(tex_rsp_valid), .tex_rsp_texels(tex_rsp_texels), .tex_rsp_tag(tex_rsp_tag),
    .tex_rsp_ready(tex_rsp_ready)
  );

  task automatic next();
    @(negedge clk);
  endtask

  task automatic idle();
    in_req_valid   = '0;
    in_req_mask    = '0;
    in_req_coords  = '0;
    in_req_lod     = '0;
    in_req_stage   = '0;
    in_req_tag     = '0;
    in_rsp_ready   = '1;
    tex_req_ready  = 1'b1;
    tex_rsp_valid  = 1'b0;
    tex_rsp_texels = '0;
    tex_rsp_tag    = '0;
  endtask

  task automatic do_reset();
    next();
    reset = 1'b1;
    idle();
    next();
    next();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    next();
    reset = 1'b1;
    idle();
    in_req_valid = 4'b1111;
    next();
    #1;
    checks++; if (tex_req_valid !== 1'b0) begin errors++; $display("FAIL reset_tex_req_valid: got %b expected 0", tex_req_valid); end
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_in_rsp_valid: got %b expected 0000", in_rsp_valid); end
    checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_req_ready: got %b expected 0000", in_req_ready); end
    checks++; if (tex_rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_tex_rsp_ready: got %b expected 1", tex_rsp_ready); end
    checks++; if (dut.pend_cnt_q !== '0) begin errors++; $display("FAIL reset_pend_cnt: got %h expected 0", dut.pend_cnt_q); end
    in_req_valid = '0;
    next();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [TW+SB-1:0] exp_tag;
    exp_tag = {8'hA5, 2'd2};
    next();
    in_req_valid = 4'b0100;
    in_req_tag[2] = 8'hA5;
    in_req_mask[2] = 4'b1011;
    in_req_stage[2] = 2'd3;
    in_req_coords[2][0][1] = 32'h1234_5678;
    in_req_lod[2][3] = 4'h7;
    #1;
    checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", in_req_ready); end
    next();
    in_req_valid = '0;
    #1;
    checks++; if (tex_req_valid !== 1'b1) begin errors++; $display("FAIL single_tex_valid: got %b expected 1", tex_req_valid); end
    checks++; if (tex_req_tag !== exp_tag) begin errors++; $display("FAIL single_tex_tag: got %h expected %h", tex_req_tag, exp_tag); end
    checks++; if (tex_req_mask !== 4'b1011) begin errors++; $display("FAIL single_tex_mask: got %b expected 1011", tex_req_mask); end
    checks++; if (tex_req_stage !== 2'd3) begin errors++; $display("FAIL single_tex_stage: got %0d expected 3", tex_req_stage); end
    checks++; if (tex_req_coords[0][1] !== 32'h1234_5678) begin errors++; $display("FAIL single_tex_coord: got %h expected 12345678", tex_req_coords[0][1]); end
    checks++; if (tex_req_lod[3] !== 4'h7) begin errors++; $display("FAIL single_tex_lod: got %h expected 7", tex_req_lod[3]); end
    next();
    tex_rsp_valid = 1'b1;
    tex_rsp_tag = exp_tag;
    tex_rsp_texels[1] = 32'hCAFE_0001;
    #1;
    checks++; if (tex_req_valid !== 1'b0) begin errors++; $display("FAIL single_tex_drained: got %b expected 0", tex_req_valid); end
    checks++; if (tex_rsp_ready !== 1'b1) begin errors++; $display("FAIL single_rsp_ready: got %b expected 1", tex_rsp_ready); end
    next();
    tex_rsp_valid = 1'b0;
    #1;
    checks++; if (in_rsp_valid !== 4'b0100) begin errors++; $display("FAIL single_in_rsp_valid: got %b expected 0100", in_rsp_valid); end
    checks++; if (in_rsp_tag !== 8'hA5) begin errors++; $display("FAIL single_in_rsp_tag: got %h expected a5", in_rsp_tag); end
    checks++; if (in_rsp_texels[1] !== 32'hCAFE_0001) begin errors++; $display("FAIL single_in_rsp_texel: got %h expected cafe0001", in_rsp_texels[1]); end
    next();
    #1;
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_rsp_done: got %b expected 0000", in_rsp_valid); end
    checks++; if (dut.pend_cnt_q[2] !== 2'd0) begin errors++; $display("FAIL single_pend2: got %0d expected 0", dut.pend_cnt_q[2]); end
  endtask

  task automatic test_round_robin();
    logic [3:0]       one;
    logic [3:0]       exp_rdy;
    logic [1:0]       s;
    logic [TW-1:0]    t;
    logic [TW+SB-1:0] exp_tag;
    one = 4'b0001;
    do_reset();
    next();
    in_req_valid = 4'b1111;
    for (int i = 0; i < N; i++) in_req_tag[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) next();
      #1;
      exp_rdy = (k < 8) ? (one << (k % 4)) : 4'b0000;
      checks++; if (in_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant_%0d: got %b expected %b", k, in_req_ready, exp_rdy); end
      if (k >= 1) begin
        s = 2'((k - 1) % 4);
        t = 8'h10 + 8'(s);
        exp_tag = {t, s};
        checks++; if (tex_req_valid !== 1'b1 || tex_req_tag !== exp_tag) begin errors++; $display("FAIL rr_tex_tag_%0d: got valid %b tag %h expected valid 1 tag %h", k, tex_req_valid, tex_req_tag, exp_tag); end
      end
    end
    next();
    in_req_valid = '0;
  endtask

  task automatic test_credits();
    do_reset();
    next();
    in_req_valid = 4'b0010;
    in_req_tag[1] = 8'h21;
    #1;
    checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL credit_first: got %b expected 0010", in_req_ready); end
    next();
    #1;
    checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL credit_second: got %b expected 0010", in_req_ready); end
    next();
    in_req_valid = 4'b0110;
    in_req_tag[2] = 8'h22;
    #1;
    checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL credit_skip_saturated: got %b expected 0100", in_req_ready); end
    next();
    in_req_valid = 4'b0010;
    tex_rsp_valid = 1'b1;
    tex_rsp_tag = {8'h21, 2'd1};
    #1;
    checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL credit_blocked: got %b expected 0000", in_req_ready); end
    next();
    tex_rsp_valid = 1'b0;
    #1;
    checks++; if (in_rsp_valid !== 4'b0010) begin errors++; $display("FAIL credit_rsp_valid: got %b expected 0010", in_rsp_valid); end
    checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL credit_still_blocked: got %b expected 0000", in_req_ready); end
    next();
    #1;
    checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL credit_reopened: got %b expected 0010", in_req_ready); end
    next();
    in_req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [TW+SB-1:0] tag_a, tag_b;
    tag_a = {8'h31, 2'd0};
    tag_b = {8'h32, 2'd0};
    do_reset();
    next();
    tex_req_ready = 1'b0;
    in_req_valid = 4'b0001;
    in_req_tag[0] = 8'h31;
    #1;
    checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_first_accept: got %b expected 0001", in_req_ready); end
    for (int k = 0; k < 5; k++) begin
      next();
      in_req_tag[0] = 8'h32;
      #1;
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL bp_no_accept_%0d: got %b expected 0000", k, in_req_ready); end
      checks++; if (tex_req_valid !== 1'b1 || tex_req_tag !== tag_a) begin errors++; $display("FAIL bp_hold_%0d: got valid %b tag %h expected valid 1 tag %h", k, tex_req_valid, tex_req_tag, tag_a); end
    end
    next();
    tex_req_ready = 1'b1;
    #1;
    checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_accept: got %b expected 0001", in_req_ready); end
    next();
    in_req_valid = '0;
    #1;
    checks++; if (tex_req_valid !== 1'b1 || tex_req_tag !== tag_b) begin errors++; $display("FAIL bp_second_req: got valid %b tag %h expected valid 1 tag %h", tex_req_valid, tex_req_tag, tag_b); end
    next();
    #1;
    checks++; if (tex_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate: got %b expected 0", tex_req_valid); end
  endtask

  task automatic test_rsp_stall();
    do_reset();
    next();
    in_req_valid = 4'b1000;
    in_req_tag[3] = 8'h43;
    #1;
    checks++; if (in_req_ready !== 4'b1000) begin errors++; $display("FAIL stall_req_accept: got %b expected 1000", in_req_ready); end
    next();
    in_req_valid = '0;
    in_rsp_ready = 4'b0111;
    next();
    tex_rsp_valid = 1'b1;
    tex_rsp_tag = {8'h43, 2'd3};
    tex_rsp_texels[0] = 32'hBEEF_0003;
    #1;
    checks++; if (tex_rsp_ready !== 1'b1) begin errors++; $display("FAIL stall_rsp_take: got %b expected 1", tex_rsp_ready); end
    for (int k = 0; k < 3; k++) begin
      next();
      tex_rsp_valid = 1'b0;
      #1;
      checks++; if (in_rsp_valid !== 4'b1000) begin errors++; $display("FAIL stall_valid_%0d: got %b expected 1000", k, in_rsp_valid); end
      checks++; if (tex_rsp_ready !== 1'b0) begin errors++; $display("FAIL stall_tex_rsp_ready_%0d: got %b expected 0", k, tex_rsp_ready); end
      checks++; if (in_rsp_texels[0] !== 32'hBEEF_0003 || in_rsp_tag !== 8'h43) begin errors++; $display("FAIL stall_hold_%0d: got texel %h tag %h expected beef0003 43", k, in_rsp_texels[0], in_rsp_tag); end
      checks++; if (dut.pend_cnt_q[3] !== 2'd1) begin errors++; $display("FAIL stall_pend_%0d: got %0d expected 1", k, dut.pend_cnt_q[3]); end
    end
    next();
    in_rsp_ready = '1;
    #1;
    checks++; if (tex_rsp_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", tex_rsp_ready); end
    next();
    #1;
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL stall_delivered: got %b expected 0000", in_rsp_valid); end
    checks++; if (dut.pend_cnt_q[3] !== 2'd0) begin errors++; $display("FAIL stall_pend_dec: got %0d expected 0", dut.pend_cnt_q[3]); end
  endtask

  task automatic test_simultaneous();
    logic [TW+SB-1:0] exp_tag;
    exp_tag = {8'h52, 2'd0};
    do_reset();
    next();
    in_req_valid = 4'b0001;
    in_req_tag[0] = 8'h51;
    next();
    in_req_valid = '0;
    next();
    tex_rsp_valid = 1'b1;
    tex_rsp_tag = {8'h51, 2'd0};
    next();
    tex_rsp_valid = 1'b0;
    in_req_valid = 4'b0001;
    in_req_tag[0] = 8'h52;
    #1;
    checks++; if (in_rsp_valid !== 4'b0001 || in_req_ready !== 4'b0001) begin errors++; $display("FAIL simul_both_fire: got rsp %b req_ready %b expected 0001 0001", in_rsp_valid, in_req_ready); end
    checks++; if (dut.pend_cnt_q[0] !== 2'd1) begin errors++; $display("FAIL simul_pend_before: got %0d expected 1", dut.pend_cnt_q[0]); end
    next();
    in_req_valid = '0;
    #1;
    checks++; if (dut.pend_cnt_q[0] !== 2'd1) begin errors++; $display("FAIL simul_pend_after: got %0d expected 1", dut.pend_cnt_q[0]); end
    checks++; if (tex_req_valid !== 1'b1 || tex_req_tag !== exp_tag) begin errors++; $display("FAIL simul_new_req: got valid %b tag %h expected valid 1 tag %h", tex_req_valid, tex_req_tag, exp_tag); end
    checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL simul_rsp_done: got %b expected 0000", in_rsp_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    next();
    tex_req_ready = 1'b0;
    in_req_valid = 4'b0001;
    in_req_tag[0] = 8'h61;
    next();
    in_req_valid = '0;
    #1;
    checks++; if (tex_req_valid !== 1'b1) begin errors++; $display("FAIL midrst_loaded: got %b expected 1", tex_req_valid); end
    reset = 1'b1;
    next();
    #1;
    checks++; if (tex_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped: got %b expected 0", tex_req_valid); end
    checks++; if (dut.pend_cnt_q[0] !== 2'd0) begin errors++; $display("FAIL midrst_pend: got %0d expected 0", dut.pend_cnt_q[0]); end
    next();
    reset = 1'b0;
    tex_req_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_single();
    test_round_robin();
    test_credits();
    test_backpressure();
    test_rsp_stall();
    test_simultaneous();
    test_mid_reset();
    next();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tex_req_arbiter.md
# tex_req_arbiter

Arbitrates texture requests from `NUM_INPUTS` requesters (core tex agents / sockets) onto the single request port of the texture unit. It then routes each texture-unit response back to the requester that issued it. It sits directly upstream of the texture unit's `VX_tex_bus_if` slave port and directly downstream of it on the response path. Each input's in-flight requests are bounded by a per-input credit counter.

## Interface
Parameters:
- `NUM_INPUTS`, 4: number of requesters; must be ≥1.
- `NUM_LANES`, 4: lanes per request.
- `TAG_WIDTH`, 8: requester tag width.
- `MAX_PENDING`, 8: maximum outstanding requests per input; must be ≥1.
- `SEL_BITS`, derived, max(1, clog2(`NUM_INPUTS`)): width of the appended source index.
- `CNT_BITS`, derived, clog2(`MAX_PENDING`+1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_req_valid`  in  [NUM_INPUTS]  per-input request valid.
- `in_req_mask`  in  [NUM_INPUTS][NUM_LANES]  lane mask.
- `in_req_coords`  in  [NUM_INPUTS][2][NUM_LANES][32]  u/v coordinates.
- `in_req_lod`  in  [NUM_INPUTS][NUM_LANES][`VX_TEX_LOD_BITS`]  per-lane LOD.
- `in_req_stage`  in  [NUM_INPUTS][`VX_TEX_STAGE_BITS`]  sampler stage.
- `in_req_tag`  in  [NUM_INPUTS][TAG_WIDTH]  requester tag.
- `in_req_ready`  out  [NUM_INPUTS]  request accepted.
- `in_rsp_valid`  out  [NUM_INPUTS]  response valid.
- `in_rsp_texels`  out  [NUM_LANES][32]  shared response texels.
- `in_rsp_tag`  out  [TAG_WIDTH]  shared response tag, original requester tag.
- `in_rsp_ready`  in  [NUM_INPUTS]  per-input response ready.
- `tex_req_valid`, `tex_req_mask`, `tex_req_coords`, `tex_req_lod`, `tex_req_stage`  out  as above, single port  to the texture unit.
- `tex_req_tag`  out  [TAG_WIDTH+SEL_BITS]  `{in_tag, sel}`, with sel in the LSBs.
- `tex_req_ready`  in  1  from the texture unit.
- `tex_rsp_valid`  in  1  from the texture unit.
- `tex_rsp_texels`  in  [NUM_LANES][32]  from the texture unit.
- `tex_rsp_tag`  in  [TAG_WIDTH+SEL_BITS]  from the texture unit.
- `tex_rsp_ready`  out  1  to the texture unit.

## Operation
- **Eligibility:** input i is eligible when `in_req_valid[i]` is set and `pend_cnt[i] < MAX_PENDING`.
- **Grant:** round-robin, one grant per cycle.
  - The search starts at pointer `rr_ptr` (reset 0). The first eligible index at or after `rr_ptr`, modulo `NUM_INPUTS`, wins.
  - On a grant to i, `rr_ptr` becomes (i+1) mod `NUM_INPUTS`. With no grant, `rr_ptr` holds.
- **Accept:** `in_req_ready[i]` = (grant == i) && `req_stage_ready`, where `req_stage_ready` = ~`req_reg_valid` | `tex_req_ready`.
  - An input that is not granted sees ready = 0.
  - `in_req_ready` must not depend on any `in_req_valid[j]` with j≠i other than through the arbiter. This is a combinational path, which is accepted.
- **Request register:** one-entry pipe register holding {mask, coords, lod, stage, {tag, sel}}. It loads on accept and clears on a `tex_req` fire with no new accept.
- **Credit counters:** `pend_cnt[i]` increments on an `in_req` fire for i and decrements on an `in_rsp` fire for i. A simultaneous fire of both leaves it unchanged.
- **Response register:** one entry {texels, tag, sel}.
  - `tex_rsp_ready` = ~`rsp_reg_valid` | `in_rsp_ready[rsp_sel]`.
  - `in_rsp_valid[i]` = `rsp_reg_valid` && `rsp_sel` == i.
  - `in_rsp_tag` = the stored tag with the sel LSBs stripped.
- **`NUM_INPUTS`=1:** sel is the constant 0 and the round-robin logic degenerates to pass-through.
- **Error checks (simulation assertions):**
  - A response arriving with sel ≥ `NUM_INPUTS`.
  - A response for an input whose `pend_cnt` is 0.
  - A `pend_cnt` overflow.

## Timing
- **Reset values:** `tex_req_valid`=0, `in_rsp_valid`=0, `in_req_ready`=0, `tex_rsp_ready`=1. All `pend_cnt`=0, `rr_ptr`=0. Data outputs are don't-care.
- **Request latency:** 1 cycle from `in_req` fire to `tex_req_valid`.
- **Response latency:** 1 cycle from `tex_rsp` fire to `in_rsp_valid`.
- **Throughput:** full, one request and one response per cycle, with back-to-back accepts while `tex_req_ready` stays high.
- **Handshake:** valid/ready throughout. Registered outputs hold stable while valid && !ready.
- **Saturation:** at `pend_cnt`=`MAX_PENDING`, the input is skipped. It becomes eligible again in the cycle after its response fires.
- **Reset mid-operation:** all in-flight state is dropped. Responses that arrive later for pre-reset requests are the environment's responsibility.

## Structure
- Package `VX_tex_pkg` holds the `SEL_BITS` and `CNT_BITS` helper functions and a `tex_arb_req_t` packed struct {mask, coords, lod, stage, tag}.
- Sub-module `tex_rr_arbiter`: an N-way round-robin grant with a pointer register, a `grant_ready` input, and `grant_valid`/`grant_index` outputs.
- The request and response registers are instances of `VX_elastic_buffer` (SIZE 1, OUT_REG 0 pipe mode).

## Test plan
- **Single input:** requests from input 2 only, with `tex_req_ready`=1 → `tex_req_tag` = {tag, 2'd2} one cycle later. The response echoes that tag → `in_rsp_valid[2]` next cycle with the original tag.
- **Round-robin:** all 4 inputs valid continuously → grant order 0,1,2,3,0,… with one grant per cycle.
- **Credits:** `MAX_PENDING`=2 with responses withheld → input 1 accepts exactly 2 requests, then `in_req_ready[1]`=0 while other inputs proceed. Releasing one response → input 1 accepted again the next cycle.
- **Backpressure:** `tex_req_ready`=0 for 5 cycles → `tex_req` data stable and no further `in_req_ready`. Releasing it → no loss or duplication.
- **Response stall:** `in_rsp_ready[3]`=0 with a response for input 3 pending → `tex_rsp_ready`=0 and the register holds. Raising `in_rsp_ready[3]` → delivered, and `pend_cnt[3]` decrements.
- **Simultaneous fire:** input 0 accepts a request and receives a response in the same cycle → `pend_cnt[0]` unchanged.
